// File: rtl/mult_pkg.sv
// mult_pkg: widths, operand/product types and tree-sizing helpers shared by the
// multiplier and its carry-save rows.
package mult_pkg;
    localparam int WIDTH = 32;
    localparam int PWIDTH = 2 * WIDTH;
    // WIDTH Baugh-Wooley rows plus one correction-constant row
    localparam int NPP = WIDTH + 1;

    typedef logic signed [WIDTH-1:0] operand_t;
    typedef logic signed [PWIDTH-1:0] product_t;

    function automatic int ops_at(input int layer);
        int n;
        n = NPP;
        for (int i = 0; i < layer; i++) n = (n / 3) * 2 + n % 3;
        return n;
    endfunction

    function automatic int num_layers();
        int n;
        int l;
        n = NPP;
        l = 0;
        while (n > 2) begin
            n = (n / 3) * 2 + n % 3;
            l++;
        end
        return l;
    endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: W-bit 3:2 carry-save adder; s + c == x + y + z modulo 2^W.
module csa_row #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);
    assign s = x ^ y ^ z;
    assign c = ((x & y) | (x & z) | (y & z)) << 1;
endmodule

// File: rtl/tree_multiplier.sv
// tree_multiplier: signed WIDTHxWIDTH multiply using Baugh-Wooley partial
// products, a Wallace tree of csa_row nodes and one registered final adder.
module tree_multiplier
    import mult_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [PWIDTH-1:0]   result
);
    localparam int NL = num_layers();

    logic [PWIDTH-1:0] pp [NPP];
    logic [PWIDTH-1:0] lvl [NL+1][NPP];
    logic [PWIDTH-1:0] result_d;
    logic [PWIDTH-1:0] result_q;

    // Sign-bit cross terms are inverted; the last row adds 2^WIDTH + 2^(PWIDTH-1)
    always_comb begin
        for (int i = 0; i < NPP; i++) pp[i] = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            for (int j = 0; j < WIDTH - 1; j++) pp[i][i+j] = a[j] & b[i];
            pp[i][i+WIDTH-1] = ~(a[WIDTH-1] & b[i]);
        end
        for (int j = 0; j < WIDTH - 1; j++) pp[WIDTH-1][j+WIDTH-1] = ~(a[j] & b[WIDTH-1]);
        pp[WIDTH-1][PWIDTH-2] = a[WIDTH-1] & b[WIDTH-1];
        pp[WIDTH][WIDTH] = 1'b1;
        pp[WIDTH][PWIDTH-1] = 1'b1;
    end

    for (genvar k = 0; k < NPP; k++) begin : g_in
        assign lvl[0][k] = pp[k];
    end

    for (genvar l = 0; l < NL; l++) begin : g_layer
        localparam int N = ops_at(l);
        localparam int T = N / 3;
        for (genvar t = 0; t < T; t++) begin : g_csa
            csa_row #(.W(PWIDTH)) u_csa (
                .x(lvl[l][3*t]),
                .y(lvl[l][3*t+1]),
                .z(lvl[l][3*t+2]),
                .s(lvl[l+1][2*t]),
                .c(lvl[l+1][2*t+1])
            );
        end
        for (genvar r = 0; r < N % 3; r++) begin : g_pass
            assign lvl[l+1][2*T+r] = lvl[l][3*T+r];
        end
        for (genvar k = 2 * T + N % 3; k < NPP; k++) begin : g_zero
            assign lvl[l+1][k] = '0;
        end
    end

    always_comb begin
        result_d = lvl[NL][0] + lvl[NL][1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result_q <= '0;
        else result_q <= result_d;
    end

    assign result = result_q;
endmodule

// File: tb/tb_tree_multiplier.sv
// tb_tree_multiplier: directed product table, random back-to-back stream against
// a plain 64-bit signed multiply, and asynchronous reset checks.
module tb_tree_multiplier;
    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[12];

    tree_multiplier dut (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .b(b),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        return 64'(sx * sy);
    endfunction

    initial begin
        logic [63:0] exp;
        checks = 0;
        failures = 0;
        tbl[0]  = '{32'd50, -32'sd40, 64'hFFFFFFFFFFFFF830};
        tbl[1]  = '{-32'sd10, 32'd325, 64'hFFFFFFFFFFFFF34E};
        tbl[2]  = '{-32'sd500, 32'd2000, 64'hFFFFFFFFFFF0BDC0};
        tbl[3]  = '{-32'sd999, 32'd999, 64'hFFFFFFFFFFF0C58F};
        tbl[4]  = '{32'd90, 32'd70, 64'h000000000000189C};
        tbl[5]  = '{-32'sd80, -32'sd65, 64'h0000000000001450};
        tbl[6]  = '{32'd98756, 32'd0, 64'h0};
        tbl[7]  = '{32'd98765, 32'd1, 64'h00000000000181CD};
        tbl[8]  = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
        tbl[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
        tbl[10] = '{32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000};
        tbl[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1};

        rst_n = 1'b0;
        a = 32'd50;
        b = -32'sd40;
        repeat (3) @(posedge clk);
        #1 chk("reset_hold", result, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("reset_release", result, 64'hFFFFFFFFFFFFF830);

        for (int i = 0; i < 12; i++) begin
            a = tbl[i].a;
            b = tbl[i].b;
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), result, tbl[i].exp);
        end

        a = 32'd0;
        b = 32'h80000000;
        @(posedge clk);
        #1 chk("zero_neg", result, 64'h0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 100 == 7) a = 32'h80000000;
            exp = model(a, b);
            @(posedge clk);
            #1 chk("stream", result, exp);
            if (i == 500) begin
                a = $urandom;
                b = $urandom;
                #2 rst_n = 1'b0;
                #1 chk("async_reset", result, 64'h0);
                @(posedge clk);
                #1 chk("reset_mid_edge", result, 64'h0);
                @(negedge clk) rst_n = 1'b1;
                exp = model(a, b);
                @(posedge clk);
                #1 chk("after_reset", result, exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
